uart_tx_flag_buf: RTL and testbench
===================================

// Module: uart_tx_flag_buf
// PURPOSE
//  Transmit-side host interface for the UART: the counterpart of the receive flag/buffer.
//  Host writes one byte into a holding register, which sets tx_full. The integrated TX FSM
//  drains the register when idle and serialises an 8N1-style frame on tx, paced by s_tick.
//  Sits between the host/bus logic and the baud-rate generator (16x oversampling tick).
// PARAMETERS
//  DBIT     8   data bits per frame, sent LSB first
//  SB_TICK  16  s_tick count for the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2)
// PORTS
//  clk           in   1     system clock, all logic on rising edge
//  reset         in   1     synchronous, active-high reset
//  wr_uart       in   1     host write strobe, one cycle per byte
//  w_data        in   DBIT  byte to send, sampled when wr_uart=1 and tx_full=0
//  s_tick        in   1     baud tick, 16 per bit period, 1-cycle pulse
//  tx_full       out  1     holding register occupied; host must not write
//  tx_done_tick  out  1     1-cycle pulse at end of stop period
//  tx            out  1     serial line, idle high, registered
// BEHAVIOUR
//  Reset (synchronous, active-high, any state): tx=1, tx_full=0, tx_done_tick=0, FSM=IDLE,
//   tick/bit counters=0, hold/shift regs=0. Mid-frame reset aborts the frame; tx=1 next edge.
//  Holding buffer: wr_uart=1 && tx_full=0 -> hold<=w_data, tx_full<=1 on that edge.
//   wr_uart=1 && tx_full=1 -> write dropped, hold unchanged (tx_full is sampled pre-edge,
//   so a write on the same cycle as an FSM transfer is also dropped).
//  FSM states IDLE, START, DATA, STOP; counters s (0..15 / 0..SB_TICK-1), n (0..DBIT-1).
//   IDLE: tx=1; s_tick ignored. If tx_full=1: shift<=hold, tx_full<=0, s<=0, ->START.
//   START: tx=0. On s_tick: s==15 -> s<=0, n<=0, ->DATA; else s<=s+1.
//   DATA: tx=shift[0]. On s_tick: s==15 -> s<=0, shift>>=1; n==DBIT-1 -> STOP else n<=n+1;
//    else s<=s+1.
//   STOP: tx=1. On s_tick: s==SB_TICK-1 -> tx_done_tick=1 for that cycle, ->IDLE; else s++.
//  Latency: wr_uart at edge k -> tx_full=1 after k; transfer at k+1; tx=0 after edge k+1.
//  Each bit lasts exactly 16 s_tick; stop lasts SB_TICK s_tick. Counters never wrap past
//   their terminal value. Buffer may be refilled during DATA/STOP: back-to-back frames
//   have exactly one idle clk between stop end and next start (the IDLE transfer cycle).
//  tx driven from a register updated alongside state (no glitches, no combinational path).
//  tx_done_tick and tx_full are independent; both may be high in the same cycle.
// STRUCTURE
//  Shared package uart_pkg: FSM state enum (IDLE/START/DATA/STOP), OVERSAMPLE=16 constant,
//   default DBIT/SB_TICK. Shared with the RX side.
//  One sub-module: uart_tx_core (FSM, counters, shift reg, tx reg); top holds the
//   hold register and tx_full flag, and connects the transfer handshake (tx_start/ack).
// TESTING
//  1 Reset held 3 cycles, then released -> tx=1, tx_full=0, tx_done_tick=0 throughout idle.
//  2 s_tick every cycle, write 0xA5 -> tx: 0 x16, then 1,0,1,0,0,1,0,1 each x16, 1 x16;
//    tx_done_tick exactly once on last stop cycle; tx_full high exactly 1 cycle.
//  3 Write 0x3C, write 0xC3 during DATA -> second frame starts 1 clk after first done tick;
//    both bytes reconstructed correctly by a bench-side 16x sampler.
//  4 Write 0x11, then 0x22 while tx_full=1 -> 0x22 dropped; only 0x11 transmitted.
//  5 Reset asserted in DATA bit 4 -> tx=1 next edge, tx_full=0, no tx_done_tick; next write
//    0x5A sends a clean full frame.
//  6 SB_TICK=32, s_tick every 4th clk, write 0xFF -> stop period 32 ticks (128 clk), done tick
//    once; tx idle-high between frames.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame timing defaults,
// used by both the transmit and receive sides.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int OVERSAMPLE      = 16;
    localparam int DEFAULT_DBIT    = 8;
    localparam int DEFAULT_SB_TICK = 16;

endpackage

// File: rtl/uart_tx_flag_buf_if.sv
// Host-side bundle of the UART transmitter: write strobe/data, baud tick,
// and the status/serial outputs.
interface uart_tx_flag_buf_if
    import uart_pkg::*;
#(
    parameter int DBIT = DEFAULT_DBIT
) ();

    logic            wr_uart;
    logic [DBIT-1:0] w_data;
    logic            s_tick;
    logic            tx_full;
    logic            tx_done_tick;
    logic            tx;

    modport master (
        output wr_uart, w_data, s_tick,
        input  tx_full, tx_done_tick, tx
    );

    modport slave (
        input  wr_uart, w_data, s_tick,
        output tx_full, tx_done_tick, tx
    );

endinterface

// File: rtl/uart_tx_core.sv
// Transmit FSM: takes a byte from the holding register when idle and
// serialises start/data/stop on a registered tx line, paced by s_tick.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DBIT    = DEFAULT_DBIT,
    parameter int SB_TICK = DEFAULT_SB_TICK
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_start_i,
    input  logic [DBIT-1:0] tx_data_i,
    input  logic            s_tick_i,
    output logic            tx_ack_o,
    output logic            tx_done_tick_o,
    output logic            tx_o
);

    localparam int SMAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
    localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
    localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    uart_state_e     state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic            tx_q, tx_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d is derived from the next state so the line changes on the same edge as the FSM
    always_comb begin
        state_d        = state_q;
        s_d            = s_q;
        n_d            = n_q;
        shift_d        = shift_q;
        tx_d           = tx_q;
        tx_ack_o       = 1'b0;
        tx_done_tick_o = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_start_i) begin
                    tx_ack_o = 1'b1;
                    shift_d  = tx_data_i;
                    s_d      = '0;
                    state_d  = START;
                    tx_d     = 1'b0;
                end
            end
            START: begin
                if (s_tick_i) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                        tx_d    = shift_q[0];
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick_i) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d     = '0;
                        shift_d = shift_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end else begin
                            n_d  = n_q + NW'(1);
                            tx_d = shift_d[0];
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (s_tick_i) begin
                    if (s_q == S_STOP_LAST) begin
                        tx_done_tick_o = 1'b1;
                        s_d            = '0;
                        state_d        = IDLE;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx_o = tx_q;

endmodule

// File: rtl/uart_tx_flag_buf.sv
// UART transmit host interface: one-byte holding register with a full flag,
// drained by the transmit core whenever it is idle.
module uart_tx_flag_buf
    import uart_pkg::*;
#(
    parameter int DBIT    = DEFAULT_DBIT,
    parameter int SB_TICK = DEFAULT_SB_TICK
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_flag_buf_if.slave  bus
);

    logic [DBIT-1:0] hold_q;
    logic            tx_full_q;
    logic            tx_ack;

    // A transfer only happens while full, so a same-cycle write is dropped either way
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q    <= '0;
            tx_full_q <= 1'b0;
        end else if (tx_ack) begin
            tx_full_q <= 1'b0;
        end else if (bus.wr_uart && !tx_full_q) begin
            hold_q    <= bus.w_data;
            tx_full_q <= 1'b1;
        end
    end

    uart_tx_core #(
        .DBIT    (DBIT),
        .SB_TICK (SB_TICK)
    ) u_core (
        .clk            (clk),
        .reset          (reset),
        .tx_start_i     (tx_full_q),
        .tx_data_i      (hold_q),
        .s_tick_i       (bus.s_tick),
        .tx_ack_o       (tx_ack),
        .tx_done_tick_o (bus.tx_done_tick),
        .tx_o           (bus.tx)
    );

    assign bus.tx_full = tx_full_q;

endmodule

// File: tb/tb_uart_tx_flag_buf.sv
// Directed bench for uart_tx_flag_buf: one instance with 1 stop bit and a tick
// every clock, one with 2 stop bits and a tick every 4th clock.
module tb_uart_tx_flag_buf;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    uart_tx_flag_buf_if #(.DBIT(8)) busA ();
    uart_tx_flag_buf_if #(.DBIT(8)) busB ();

    uart_tx_flag_buf #(.DBIT(8), .SB_TICK(16)) dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (busA.slave)
    );

    uart_tx_flag_buf #(.DBIT(8), .SB_TICK(32)) dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (busB.slave)
    );

    always #5 clk = ~clk;

    // Advance one clock; instance B gets its tick on every 4th cycle
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        busB.s_tick = (cyc % 4 == 0);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit sel, input logic [7:0] b);
        if (sel) begin
            busB.wr_uart = 1'b1;
            busB.w_data  = b;
        end else begin
            busA.wr_uart = 1'b1;
            busA.w_data  = b;
        end
        step();
        busA.wr_uart = 1'b0;
        busB.wr_uart = 1'b0;
    endtask

    // Cycle-exact frame check on instance A, entered right after the write edge
    task automatic checkFrameA(input logic [7:0] b, input string tag);
        logic expTx;
        checkOutput({tag, ".fullAfterWrite"}, busA.tx_full, 1);
        checkOutput({tag, ".txAfterWrite"}, busA.tx, 1);
        for (int i = 0; i < 160; i++) begin
            step();
            if (i < 16)       expTx = 1'b0;
            else if (i < 144) expTx = b[(i - 16) / 16];
            else              expTx = 1'b1;
            checkOutput($sformatf("%s.tx[%0d]", tag, i), busA.tx, expTx);
            checkOutput($sformatf("%s.done[%0d]", tag, i), busA.tx_done_tick, (i == 159));
            if (i == 0) checkOutput({tag, ".fullCleared"}, busA.tx_full, 0);
        end
        step();
        checkOutput({tag, ".idleTx"}, busA.tx, 1);
        checkOutput({tag, ".idleDone"}, busA.tx_done_tick, 0);
    endtask

    // 16x mid-bit sampler on instance A; may pulse a write at a given frame cycle
    task automatic rxFrame(input int injectAt, input logic [7:0] injB,
                           output logic [7:0] data, output bit ok);
        int idx = 0;
        int waited = 0;
        ok   = 1'b1;
        data = '0;
        while (busA.tx !== 1'b0 && waited < 500) begin
            step();
            waited++;
        end
        if (busA.tx !== 1'b0) begin
            ok = 1'b0;
        end else begin
            for (int k = 0; k < 8 + 16 * 9; k++) begin
                if (idx == injectAt) begin
                    busA.wr_uart = 1'b1;
                    busA.w_data  = injB;
                end
                step();
                busA.wr_uart = 1'b0;
                idx++;
                if (idx == 8 && busA.tx !== 1'b0) ok = 1'b0;
                if (idx >= 24 && idx <= 136 && (idx - 24) % 16 == 0)
                    data[(idx - 24) / 16] = busA.tx;
            end
            if (busA.tx !== 1'b1) ok = 1'b0;
        end
    endtask

    task automatic waitDoneA(input string tag);
        int w = 0;
        while (busA.tx_done_tick !== 1'b1 && w < 200) begin
            step();
            w++;
        end
        checkOutput({tag, ".doneSeen"}, busA.tx_done_tick, 1);
    endtask

    initial begin
        logic [7:0] d;
        bit         ok;
        int         cnt;
        int         lowCycles;
        int         doneIdx;
        bit         sawLow;
        int         doneCnt;

        busA.wr_uart = 1'b0;
        busA.w_data  = '0;
        busA.s_tick  = 1'b1;
        busB.wr_uart = 1'b0;
        busB.w_data  = '0;
        busB.s_tick  = 1'b0;

        $display("[TB] reset and idle");
        reset = 1'b1;
        repeat (3) step();
        checkOutput("rst.tx", busA.tx, 1);
        checkOutput("rst.full", busA.tx_full, 0);
        checkOutput("rst.done", busA.tx_done_tick, 0);
        checkOutput("rstB.tx", busB.tx, 1);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput($sformatf("idle.tx[%0d]", i), busA.tx, 1);
            checkOutput($sformatf("idle.full[%0d]", i), busA.tx_full, 0);
            checkOutput($sformatf("idle.done[%0d]", i), busA.tx_done_tick, 0);
        end

        $display("[TB] single frame 0xA5");
        applyStimulus(0, 8'hA5);
        checkFrameA(8'hA5, "fA5");

        $display("[TB] back-to-back frames 0x3C then 0xC3");
        applyStimulus(0, 8'h3C);
        rxFrame(40, 8'hC3, d, ok);
        checkOutput("b2b.ok1", ok, 1);
        checkOutput("b2b.data1", d, 8'h3C);
        checkOutput("b2b.refilled", busA.tx_full, 1);
        waitDoneA("b2b.f1");
        step();
        checkOutput("b2b.gapTx", busA.tx, 1);
        checkOutput("b2b.gapDone", busA.tx_done_tick, 0);
        checkOutput("b2b.gapFull", busA.tx_full, 1);
        step();
        checkOutput("b2b.start2Tx", busA.tx, 0);
        checkOutput("b2b.start2Full", busA.tx_full, 0);
        rxFrame(-1, 8'h00, d, ok);
        checkOutput("b2b.ok2", ok, 1);
        checkOutput("b2b.data2", d, 8'hC3);
        waitDoneA("b2b.f2");
        step();

        $display("[TB] write while full is dropped");
        applyStimulus(0, 8'h11);
        busA.wr_uart = 1'b1;
        busA.w_data  = 8'h22;
        step();
        busA.wr_uart = 1'b0;
        checkOutput("drop.full", busA.tx_full, 0);
        checkOutput("drop.txStart", busA.tx, 0);
        rxFrame(-1, 8'h00, d, ok);
        checkOutput("drop.ok", ok, 1);
        checkOutput("drop.data", d, 8'h11);
        waitDoneA("drop");
        sawLow = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (busA.tx !== 1'b1) sawLow = 1'b1;
        end
        checkOutput("drop.noSecondFrame", sawLow, 0);
        checkOutput("drop.fullIdle", busA.tx_full, 0);

        $display("[TB] reset during data bit 4");
        applyStimulus(0, 8'h0F);
        for (int i = 0; i < 86; i++) step();
        checkOutput("abort.bit4Tx", busA.tx, 0);
        reset = 1'b1;
        step();
        checkOutput("abort.tx", busA.tx, 1);
        checkOutput("abort.full", busA.tx_full, 0);
        checkOutput("abort.done", busA.tx_done_tick, 0);
        reset = 1'b0;
        sawLow  = 1'b0;
        doneCnt = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (busA.tx !== 1'b1) sawLow = 1'b1;
            if (busA.tx_done_tick === 1'b1) doneCnt++;
        end
        checkOutput("abort.quietTx", sawLow, 0);
        checkOutput("abort.noDone", doneCnt, 0);
        applyStimulus(0, 8'h5A);
        checkFrameA(8'h5A, "f5A");

        $display("[TB] two stop bits, tick every 4th clock");
        applyStimulus(1, 8'hFF);
        checkOutput("sb32.full", busB.tx_full, 1);
        cnt = 0;
        while (busB.tx !== 1'b0 && cnt < 20) begin
            step();
            cnt++;
        end
        checkOutput("sb32.startSeen", busB.tx, 0);
        lowCycles = 0;
        while (busB.tx === 1'b0 && lowCycles < 100) begin
            step();
            lowCycles++;
        end
        checkOutput("sb32.startLen", (lowCycles >= 61 && lowCycles <= 64), 1);
        doneIdx = 0;
        sawLow  = 1'b0;
        while (busB.tx_done_tick !== 1'b1 && doneIdx < 800) begin
            step();
            doneIdx++;
            if (busB.tx !== 1'b1) sawLow = 1'b1;
        end
        checkOutput("sb32.doneIdx", doneIdx, 639);
        checkOutput("sb32.highThroughFrame", sawLow, 0);
        doneCnt = 0;
        sawLow  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (busB.tx_done_tick === 1'b1) doneCnt++;
            if (busB.tx !== 1'b1) sawLow = 1'b1;
        end
        checkOutput("sb32.singleDone", doneCnt, 0);
        checkOutput("sb32.idleHigh", sawLow, 0);
        checkOutput("sb32.fullIdle", busB.tx_full, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
